// File: rtl/uart_tx_frame_gen_if.sv
// uart_tx_frame_gen_if: byte handshake and serial line bundle between upstream and the UART transmitter.
interface uart_tx_frame_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;
    modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, input TX_OUT, Busy);
    modport slave (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx_frame_gen.sv
// uart_tx_frame_gen: serializes one byte per frame (start, LSB-first data, optional parity, stop), one bit per CLK.
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH    = 8,
    parameter int COUNTER_WIDTH = 4
) (
    input logic               CLK,
    input logic               RST,
    uart_tx_frame_gen_if.slave tx
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic                     par_en_q, par_en_d;
    logic                     par_typ_q, par_typ_d;
    logic                     par_q, par_d;
    logic                     tx_q, tx_d;
    logic                     busy_q, busy_d;
    logic                     last;

    assign last = cnt_q == COUNTER_WIDTH'(DATA_WIDTH - 1);

    always_comb begin
        state_d   = IDLE;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_d     = par_q;
        case (state_q)
            IDLE: if (tx.Data_Valid) begin
                state_d   = START;
                shift_d   = tx.P_DATA;
                par_en_d  = tx.PAR_EN;
                par_typ_d = tx.PAR_TYP;
                par_d     = ^tx.P_DATA;
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                shift_d = shift_q >> 1;
                cnt_d   = last ? cnt_q : cnt_q + COUNTER_WIDTH'(1);
                state_d = !last ? DATA : par_en_q ? PARITY : STOP;
            end
            PARITY: state_d = STOP;
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so TX_OUT and Busy stay registered.
        tx_d   = state_d == START  ? 1'b0 :
                 state_d == DATA   ? shift_d[0] :
                 state_d == PARITY ? par_q ^ par_typ_q : 1'b1;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx.TX_OUT = tx_q;
    assign tx.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// tb_uart_tx_frame_gen: frame-queue model checked every cycle, plus literal frame sequences.
module tb_uart_tx_frame_gen;
    logic CLK = 1'b0;
    logic RST;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic exp_tx = 1'b1;
    logic exp_busy = 1'b0;
    logic q[$];

    uart_tx_frame_gen_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame_gen #(.DATA_WIDTH(8), .COUNTER_WIDTH(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .tx (bus)
    );

    always #5 CLK = ~CLK;

    // Model: an idle line accepts a byte and queues its whole frame; one queued bit leaves per cycle.
    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            q.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end else begin
            if (q.size() == 0 && !exp_busy && bus.Data_Valid) begin
                q.push_back(1'b0);
                for (int i = 0; i < 8; i++) q.push_back(bus.P_DATA[i]);
                if (bus.PAR_EN) q.push_back(^bus.P_DATA ^ bus.PAR_TYP);
                q.push_back(1'b1);
            end
            if (q.size() != 0) begin
                exp_tx   = q.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (cyc > 0) begin
            tests++;
            if (bus.TX_OUT !== exp_tx || bus.Busy !== exp_busy) begin
                fails++;
                $display("FAIL model cyc=%0d tx/busy got %b%b expected %b%b", cyc, bus.TX_OUT, bus.Busy, exp_tx, exp_busy);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // mode 0: plain frame, 1: disturb inputs mid-frame, 2: hold Data_Valid and switch to 0xAA, 3: stop early
    task automatic frame(input logic [7:0] d, input logic pen, input logic ptyp,
                         input logic [0:20] seq, input int n, input int mode);
        bus.P_DATA = d; bus.PAR_EN = pen; bus.PAR_TYP = ptyp; bus.Data_Valid = 1'b1;
        @(negedge CLK);
        if (mode == 2) bus.P_DATA = 8'hAA;
        else bus.Data_Valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("tx[%0d] of %0h", i, d), {31'd0, bus.TX_OUT}, {31'd0, seq[i]});
            chk($sformatf("busy[%0d] of %0h", i, d), {31'd0, bus.Busy}, (mode == 2 && i == 10) ? 0 : 1);
            if (mode == 1 && i == 3) begin
                bus.P_DATA = 8'hFF; bus.PAR_EN = 1'b1; bus.Data_Valid = 1'b1;
            end
            if (mode == 1 && i == 4) bus.Data_Valid = 1'b0;
            if (mode == 2 && i == 20) bus.Data_Valid = 1'b0;
            @(negedge CLK);
        end
        if (mode != 3) begin
            chk($sformatf("idle tx after %0h", d), {31'd0, bus.TX_OUT}, 1);
            chk($sformatf("idle busy after %0h", d), {31'd0, bus.Busy}, 0);
            @(negedge CLK);
            chk($sformatf("still idle after %0h", d), {31'd0, bus.Busy}, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        bus.Data_Valid = 1'b1; bus.P_DATA = 8'h00; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("reset tx", {31'd0, bus.TX_OUT}, 1);
            chk("reset busy", {31'd0, bus.Busy}, 0);
        end
        RST = 1'b0;
        frame(8'h00, 1'b0, 1'b0, 21'b0000000001_00000000000, 10, 0);
        frame(8'hA5, 1'b0, 1'b0, 21'b0101001011_00000000000, 10, 0);
        frame(8'h01, 1'b1, 1'b0, 21'b01000000011_0000000000, 11, 0);
        frame(8'h01, 1'b1, 1'b1, 21'b01000000001_0000000000, 11, 0);
        frame(8'hA5, 1'b1, 1'b0, 21'b01010010101_0000000000, 11, 0);
        frame(8'h3C, 1'b0, 1'b0, 21'b0001111001_00000000000, 10, 1);
        bus.PAR_EN = 1'b0;
        frame(8'h55, 1'b0, 1'b0, 21'b010101010110010101011, 21, 2);
        frame(8'h0F, 1'b0, 1'b0, 21'b0111_00000000000000000, 4, 3);
        chk("4th data bit of 0f", {31'd0, bus.TX_OUT}, 1);
        RST = 1'b1; bus.Data_Valid = 1'b1; bus.P_DATA = 8'h81;
        @(negedge CLK);
        chk("midframe reset tx", {31'd0, bus.TX_OUT}, 1);
        chk("midframe reset busy", {31'd0, bus.Busy}, 0);
        RST = 1'b0;
        frame(8'h81, 1'b0, 1'b0, 21'b0100000011_00000000000, 10, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame_gen.md
Name: uart_tx_frame_gen

Overview:
UART transmitter. Counterpart to the UART receive path in the same UART block.
- Accepts a parallel byte with a valid strobe.
- Serializes it into one UART frame on TX_OUT: start bit, data LSB-first, optional parity, one stop bit.
- Shifts one bit per CLK cycle. CLK is the TX baud clock, already divided from the system clock upstream.
- Drives Busy so the upstream register file or FIFO reader knows when to present the next byte.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
COUNTER_WIDTH, 4, width of the internal bit counter; must hold DATA_WIDTH+3.

Ports:
CLK  input  1  TX baud clock, one bit per cycle
RST  input  1  synchronous reset, active-high, sampled on rising CLK
P_DATA  input  DATA_WIDTH  parallel byte to transmit
Data_Valid  input  1  P_DATA valid strobe, sampled on rising CLK
PAR_EN  input  1  1 = append parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line, registered, idles high
Busy  output  1  registered, high while a frame is on the line

Behaviour:
- Clocking and reset: one clock (CLK). Reset is synchronous and active-high (RST). All outputs are registered; no combinational path from inputs to outputs.
- Reset values: TX_OUT=1, Busy=0, state=IDLE, bit counter=0, shift register=0, latched parity config=0.
- Reset mid-frame: on the first CLK edge with RST=1 the frame is abandoned. TX_OUT=1 and Busy=0 from that edge. No partial frame resumes after reset.
- States:
  - IDLE: TX_OUT=1, Busy=0.
  - START: TX_OUT=0.
  - DATA: TX_OUT=shift[0].
  - PARITY: TX_OUT=parity bit.
  - STOP: TX_OUT=1.
- Acceptance:
  - A byte is accepted on the edge where state=IDLE, Data_Valid=1 and RST=0.
  - At that edge P_DATA is latched into the shift register, and PAR_EN/PAR_TYP are latched.
  - The parity bit is computed from the latched data: XOR-reduce, inverted when PAR_TYP=1.
  - Next state is START.
- Latency: the start bit appears on TX_OUT one cycle after the accepting edge. Busy rises in the same cycle.
- Transitions:
  - IDLE->START on acceptance.
  - START->DATA after 1 cycle.
  - DATA lasts DATA_WIDTH cycles, shifting right each cycle. The bit counter counts 0..DATA_WIDTH-1.
  - DATA->PARITY if latched PAR_EN=1, else DATA->STOP.
  - PARITY->STOP after 1 cycle.
  - STOP->IDLE after 1 cycle.
- Frame length: DATA_WIDTH+2 cycles without parity (10), DATA_WIDTH+3 cycles with parity (11). Busy is high for exactly those cycles.
- Back-to-back frames: Data_Valid is sampled only in IDLE. After STOP there is at least one IDLE cycle (TX_OUT=1, Busy=0) before the next start bit. The minimum frame period is therefore frame length + 1.
- Data_Valid while Busy=1 is ignored. The byte is dropped, not queued. Upstream must hold Data_Valid until it sees Busy=0.
- Data_Valid held high continuously: a new frame is accepted in every IDLE cycle, using P_DATA as sampled at that edge.
- Changes to P_DATA, PAR_EN or PAR_TYP while Busy=1 have no effect on the current frame.
- Illegal or unused state encodings return to IDLE on the next edge with TX_OUT=1.
- The bit counter clears on entry to DATA and never wraps within a frame.

Test Plan:
1. Reset sequence: RST=1 for 2 cycles, Data_Valid=1 -> TX_OUT=1 and Busy=0 throughout; no frame starts until the first edge after RST falls.
2. Byte without parity: P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. Busy is high for exactly 10 cycles starting one cycle after acceptance, then TX_OUT=1 and Busy=0.
3. Parity types: 0x01 with PAR_EN=1, PAR_TYP=0 -> 0,1,0,0,0,0,0,0,0,1,1 (parity 1). 0x01 with PAR_TYP=1 -> parity bit 0. 0xA5 with even parity -> parity bit 0. Busy is high for 11 cycles in each case.
4. Ignore while busy and config latching: accept 0x3C, then during the data bits drive P_DATA=0xFF, PAR_EN=1 and pulse Data_Valid -> frame still carries 0x3C with no parity bit. No second frame starts unless Data_Valid is high in an IDLE cycle.
5. Back-to-back: Data_Valid held high with 0x55 then 0xAA, PAR_EN=0 -> two complete frames separated by exactly one idle-high cycle after the stop bit; 21 cycles from the first start bit to the end of the second stop bit.
6. Reset mid-frame: RST=1 during the 4th data bit of 0x0F -> TX_OUT=1 and Busy=0 from that edge. With RST low and Data_Valid=1 carrying 0x81, a fresh, correct frame starts one cycle later.
